card_grid: RTL and testbench

CARD_GRID -- requirements
Module: card_grid

---
 rtl/card_pkg.sv | 19 +
 rtl/card_grid_if.sv | 33 +++
 rtl/card_cell.sv | 37 +++
 rtl/card_grid.sv | 185 ++++++++++++++++++
 tb/tb_card_grid.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/card_pkg.sv
// Shared encodings for the card_grid memory game.
//   ctrl_state_e : controller states (FIRST, SECOND, COMPARE, SHOW_FAIL)
//   card_state_e : per-card state (DOWN, SELECTED, REMOVED)
package card_pkg;

    typedef enum logic [1:0] {
        ST_FIRST     = 2'd0,
        ST_SECOND    = 2'd1,
        ST_COMPARE   = 2'd2,
        ST_SHOW_FAIL = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CARD_DOWN     = 2'd0,
        CARD_SELECTED = 2'd1,
        CARD_REMOVED  = 2'd2
    } card_state_e;

endpackage

// File: rtl/card_grid_if.sv
// Player/display bundle of the card grid.
//   master : drives cursor, select button and face table
//   slave  : drives selection/blink/hidden maps, match pulses, busy, pairs_left, done
interface card_grid_if #(
    parameter int unsigned N_CARDS = 16,
    parameter int unsigned ID_W    = 3
);
    localparam int unsigned IDX_W = $clog2(N_CARDS);
    localparam int unsigned CNT_W = $clog2(N_CARDS / 2 + 1);

    logic [IDX_W-1:0]        cur_idx;
    logic                    s;
    logic [N_CARDS*ID_W-1:0] faces;
    logic [N_CARDS-1:0]      sel;
    logic [N_CARDS-1:0]      blink;
    logic [N_CARDS-1:0]      hidden;
    logic                    match_ok;
    logic                    match_fail;
    logic                    busy;
    logic [CNT_W-1:0]        pairs_left;
    logic                    done;

    modport master (
        output cur_idx, s, faces,
        input  sel, blink, hidden, match_ok, match_fail, busy, pairs_left, done
    );

    modport slave (
        input  cur_idx, s, faces,
        output sel, blink, hidden, match_ok, match_fail, busy, pairs_left, done
    );

endinterface

// File: rtl/card_cell.sv
// State of one card: face down, selected (face up) or removed.
//   clk, rst   : clock, synchronous active-high reset
//   set_sel    : turn a face-down card up
//   clr_sel    : turn a selected card back down
//   set_hidden : remove the card (wins over clr_sel)
//   sel, hidden: decoded state
module card_cell
    import card_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic set_sel,
    input  logic clr_sel,
    input  logic set_hidden,
    output logic sel,
    output logic hidden
);

    card_state_e state_q;

    // Removal has priority so a matched pair never flashes back face down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CARD_DOWN;
        end else if (set_hidden) begin
            state_q <= CARD_REMOVED;
        end else if (clr_sel && state_q == CARD_SELECTED) begin
            state_q <= CARD_DOWN;
        end else if (set_sel && state_q == CARD_DOWN) begin
            state_q <= CARD_SELECTED;
        end
    end

    assign sel    = (state_q == CARD_SELECTED);
    assign hidden = (state_q == CARD_REMOVED);

endmodule

// File: rtl/card_grid.sv
// Memory-game controller: pick two cards, remove them if their faces match,
// otherwise show them for FAIL_HOLD cycles and turn them back down.
//   clk, rst : clock, synchronous active-high reset
//   bus      : card_grid_if slave (cursor, select button, faces in;
//              sel/blink/hidden maps, match pulses, busy, pairs_left, done out)
module card_grid
    import card_pkg::*;
#(
    parameter int unsigned N_CARDS   = 16,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned BLINK_DIV = 4,
    parameter int unsigned FAIL_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    card_grid_if.slave bus
);

    localparam int unsigned IDX_W  = $clog2(N_CARDS);
    localparam int unsigned SPAN   = 1 << IDX_W;
    localparam int unsigned CNT_W  = $clog2(N_CARDS / 2 + 1);
    localparam int unsigned BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned HOLD_W = (FAIL_HOLD > 1) ? $clog2(FAIL_HOLD) : 1;

    ctrl_state_e        state_q;
    logic               s_q;
    logic [IDX_W-1:0]   a_q;
    logic [IDX_W-1:0]   b_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [BLK_W-1:0]   blink_cnt_q;
    logic               phase_q;
    logic [N_CARDS-1:0] blink_q;
    logic               match_ok_q;
    logic               match_fail_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   pairs_q;

    logic [N_CARDS-1:0] sel_v;
    logic [N_CARDS-1:0] hidden_v;
    logic [SPAN-1:0]    in_range_c;
    logic [SPAN-1:0]    sel_pad_c;
    logic [SPAN-1:0]    hidden_pad_c;
    logic [N_CARDS-1:0] cursor_oh_c;
    logic [N_CARDS-1:0] set_sel_c;
    logic [N_CARDS-1:0] set_hidden_c;
    logic               clr_sel_c;
    logic               sel_event_c;
    logic               take_c;
    logic [ID_W-1:0]    face_a_c;
    logic [ID_W-1:0]    face_b_c;
    logic               faces_eq_c;
    logic               hold_end_c;

    // Cursor values past the last card (non power-of-two grids) are padded out.
    always_comb begin
        in_range_c = '0;
        for (int unsigned j = 0; j < SPAN; j++) begin
            in_range_c[j] = (j < N_CARDS);
        end
    end

    assign sel_pad_c    = SPAN'(sel_v);
    assign hidden_pad_c = SPAN'(hidden_v);
    assign cursor_oh_c  = N_CARDS'(1) << bus.cur_idx;

    assign sel_event_c = bus.s & ~s_q;
    assign take_c      = sel_event_c & ~busy_q & ~done_q
                       & in_range_c[bus.cur_idx]
                       & ~sel_pad_c[bus.cur_idx]
                       & ~hidden_pad_c[bus.cur_idx];

    assign face_a_c   = bus.faces[32'(a_q) * ID_W +: ID_W];
    assign face_b_c   = bus.faces[32'(b_q) * ID_W +: ID_W];
    assign faces_eq_c = (face_a_c == face_b_c);
    assign hold_end_c = (hold_q == HOLD_W'(FAIL_HOLD - 1));

    // Per-card strobes; they land in the cells on the same edge the FSM moves.
    always_comb begin
        set_sel_c    = '0;
        set_hidden_c = '0;
        clr_sel_c    = 1'b0;
        if (take_c) begin
            set_sel_c = cursor_oh_c;
        end
        if (state_q == ST_COMPARE && faces_eq_c) begin
            set_hidden_c = (N_CARDS'(1) << a_q) | (N_CARDS'(1) << b_q);
            clr_sel_c    = 1'b1;
        end
        if (state_q == ST_SHOW_FAIL && hold_end_c) begin
            clr_sel_c = 1'b1;
        end
    end

    for (genvar i = 0; i < N_CARDS; i++) begin : g_cell
        card_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .set_sel   (set_sel_c[i]),
            .clr_sel   (clr_sel_c),
            .set_hidden(set_hidden_c[i]),
            .sel       (sel_v[i]),
            .hidden    (hidden_v[i])
        );
    end

    // Controller, select edge detector and blink divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FIRST;
            s_q          <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            hold_q       <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            blink_q      <= '0;
            match_ok_q   <= 1'b0;
            match_fail_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pairs_q      <= CNT_W'(N_CARDS / 2);
        end else begin
            s_q          <= bus.s;
            match_ok_q   <= 1'b0;
            match_fail_q <= 1'b0;

            if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLK_W'(1);
            end
            blink_q <= phase_q ? (cursor_oh_c & ~sel_v & ~hidden_v) : '0;

            case (state_q)
                ST_FIRST: begin
                    if (take_c) begin
                        a_q     <= bus.cur_idx;
                        state_q <= ST_SECOND;
                    end
                end
                ST_SECOND: begin
                    if (take_c) begin
                        b_q     <= bus.cur_idx;
                        busy_q  <= 1'b1;
                        state_q <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (faces_eq_c) begin
                        match_ok_q <= 1'b1;
                        pairs_q    <= pairs_q - CNT_W'(1);
                        done_q     <= (pairs_q == CNT_W'(1));
                        busy_q     <= 1'b0;
                        state_q    <= ST_FIRST;
                    end else begin
                        match_fail_q <= 1'b1;
                        hold_q       <= '0;
                        state_q      <= ST_SHOW_FAIL;
                    end
                end
                ST_SHOW_FAIL: begin
                    if (hold_end_c) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_FIRST;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                default: state_q <= ST_FIRST;
            endcase
        end
    end

    assign bus.sel        = sel_v;
    assign bus.hidden     = hidden_v;
    assign bus.blink      = blink_q;
    assign bus.match_ok   = match_ok_q;
    assign bus.match_fail = match_fail_q;
    assign bus.busy       = busy_q;
    assign bus.pairs_left = pairs_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_card_grid.sv
// Scoreboard bench for card_grid: directed game scenarios plus random games,
// checked against a pair-level model of the memory game.
module tb_card_grid;

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned BD  = 4;
    localparam int unsigned FH  = 8;
    localparam int unsigned IW  = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    card_grid_if #(.N_CARDS(N), .ID_W(IDW)) bus ();

    card_grid #(
        .N_CARDS  (N),
        .ID_W     (IDW),
        .BLINK_DIV(BD),
        .FAIL_HOLD(FH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        bit           ok;
        logic [N-1:0] sel;
        logic [N-1:0] hidden;
        int           pairs;
    } exp_t;

    int unsigned  face_tab [N] = '{1, 2, 1, 2};
    logic [N-1:0] m_hidden;
    logic [N-1:0] m_sel;
    int           m_first;
    int           m_pairs;
    int           cur;
    int unsigned  n_edges = 0;
    exp_t         exp_q [$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;

    // Clock edges since reset was last released, for the blink phase.
    always @(posedge clk) n_edges <= rst ? 0 : n_edges + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Blink after m edges reflects the phase and card state one edge earlier.
    function automatic logic [N-1:0] exp_blink(int unsigned m, int c,
                                               logic [N-1:0] s_m, logic [N-1:0] h_m);
        logic [N-1:0] r;
        r = '0;
        if (m > 0 && (((m - 1) / BD) % 2) == 1 && !s_m[c] && !h_m[c]) r[c] = 1'b1;
        return r;
    endfunction

    // Monitor: every match pulse must agree with the oldest predicted outcome.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.match_ok || bus.match_fail) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, bus.match_ok, bus.match_fail}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind", {30'd0, bus.match_ok, bus.match_fail},
                          mon_e.ok ? 32'd2 : 32'd1);
                    check("pulse_sel", 32'(bus.sel), 32'(mon_e.sel));
                    check("pulse_hidden", 32'(bus.hidden), 32'(mon_e.hidden));
                    check("pulse_pairs", 32'(bus.pairs_left), 32'(mon_e.pairs));
                end
            end
        end
    end

    task automatic model_reset();
        m_hidden = '0;
        m_sel    = '0;
        m_first  = -1;
        m_pairs  = N / 2;
        exp_q.delete();
    endtask

    // Game rules at pair level; a completed pair pushes its predicted outcome.
    task automatic model_press(int idx, output bit second, output bit ok);
        exp_t e;
        second = 1'b0;
        ok     = 1'b0;
        if (m_pairs == 0 || m_hidden[idx] || m_sel[idx]) return;
        if (m_first < 0) begin
            m_first     = idx;
            m_sel[idx]  = 1'b1;
        end else begin
            second = 1'b1;
            ok     = (face_tab[m_first] == face_tab[idx]);
            e.ok   = ok;
            if (ok) begin
                e.sel    = '0;
                e.hidden = m_hidden | m_sel | (N'(1) << idx);
                e.pairs  = m_pairs - 1;
            end else begin
                e.sel    = m_sel | (N'(1) << idx);
                e.hidden = m_hidden;
                e.pairs  = m_pairs;
            end
            exp_q.push_back(e);
            m_hidden = e.hidden;
            m_pairs  = e.pairs;
            m_sel    = '0;
            m_first  = -1;
        end
    endtask

    // Called at a negedge; returns at a negedge with s low for one full edge.
    task automatic press(int idx, int hold);
        bus.cur_idx = IW'(idx);
        cur         = idx;
        bus.s       = 1'b1;
        repeat (hold) @(negedge clk);
        bus.s = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (FH + 2) @(negedge clk);
    endtask

    task automatic do_press(int idx, int hold);
        bit second;
        bit ok;
        model_press(idx, second, ok);
        press(idx, hold);
        if (second) begin
            if (!ok && $urandom_range(0, 1) == 1) press($urandom_range(0, N - 1), 1);
            settle();
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        bus.s = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_idle(string tag);
        check({tag, "_sel"}, 32'(bus.sel), 32'(m_sel));
        check({tag, "_hidden"}, 32'(bus.hidden), 32'(m_hidden));
        check({tag, "_pairs"}, 32'(bus.pairs_left), 32'(m_pairs));
        check({tag, "_done"}, 32'(bus.done), (m_pairs == 0) ? 32'd1 : 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_blink"}, 32'(bus.blink), 32'(exp_blink(n_edges, cur, m_sel, m_hidden)));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sec;
        bit okb;
        bus.faces   = {2'd2, 2'd1, 2'd2, 2'd1};
        bus.cur_idx = IW'(1);
        cur         = 1;
        bus.s       = 1'b0;

        // Reset values, then free-running blink on card 1.
        do_reset();
        check_idle("reset");
        check("reset_ok", 32'(bus.match_ok), 32'd0);
        check("reset_fail", 32'(bus.match_fail), 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("blink_idle", 32'(bus.blink), 32'(exp_blink(n_edges, 1, '0, '0)));
        end

        // Matching pair 0/2 with exact pulse timing.
        do_press(0, 1);
        check_idle("pick0");
        model_press(2, sec, okb);
        bus.cur_idx = IW'(2);
        cur         = 2;
        bus.s       = 1'b1;
        @(negedge clk);
        check("pair_sel", 32'(bus.sel), 32'h5);
        check("pair_busy", 32'(bus.busy), 32'd1);
        check("ok_early", 32'(bus.match_ok), 32'd0);
        bus.s = 1'b0;
        @(negedge clk);
        check("ok_pulse", 32'(bus.match_ok), 32'd1);
        check("ok_hidden", 32'(bus.hidden), 32'h5);
        check("ok_sel", 32'(bus.sel), 32'h0);
        check("ok_pairs", 32'(bus.pairs_left), 32'd1);
        @(negedge clk);
        check("ok_one_cycle", 32'(bus.match_ok), 32'd0);
        settle();
        check_idle("after_ok");

        // Second pair finishes the game; later selects are ignored.
        do_press(1, 1);
        do_press(3, 1);
        check_idle("all_done");
        do_press(0, 1);
        do_press(2, 3);
        check_idle("done_ignore");

        // Mismatch 1/2: eight-cycle hold, with a select attempt while busy.
        do_reset();
        do_press(1, 1);
        model_press(2, sec, okb);
        bus.cur_idx = IW'(2);
        cur         = 2;
        bus.s       = 1'b1;
        @(negedge clk);
        check("fail_cmp_sel", 32'(bus.sel), 32'h6);
        check("fail_early", 32'(bus.match_fail), 32'd0);
        bus.s = 1'b0;
        for (int k = 2; k < 10; k++) begin
            @(negedge clk);
            if (k == 2) check("fail_pulse", 32'(bus.match_fail), 32'd1);
            check("fail_hold_sel", 32'(bus.sel), 32'h6);
            check("fail_hold_busy", 32'(bus.busy), 32'd1);
            if (k == 3) begin
                bus.cur_idx = IW'(0);
                cur         = 0;
                bus.s       = 1'b1;
            end
            if (k == 4) bus.s = 1'b0;
        end
        @(negedge clk);
        check("fail_release_sel", 32'(bus.sel), 32'h0);
        check("fail_release_hidden", 32'(bus.hidden), 32'h0);
        repeat (2) @(negedge clk);
        check_idle("after_fail");

        // Long press and reselect give a single selection.
        do_press(1, 5);
        check_idle("long_press");
        do_press(1, 1);
        check_idle("reselect");

        // Reset in the middle of SHOW_FAIL.
        model_press(0, sec, okb);
        press(0, 1);
        repeat (3) @(negedge clk);
        do_reset();
        check_idle("rst_showfail");

        // Reset during COMPARE aborts the pulse and beats a coincident select.
        do_press(0, 1);
        model_press(3, sec, okb);
        bus.cur_idx = IW'(3);
        cur         = 3;
        bus.s       = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        bus.s       = 1'b0;
        bus.cur_idx = IW'(2);
        cur         = 2;
        @(negedge clk);
        check("abort_ok", 32'(bus.match_ok), 32'd0);
        check("abort_fail", 32'(bus.match_fail), 32'd0);
        bus.s = 1'b1;
        @(negedge clk);
        bus.s = 1'b0;
        rst   = 1'b0;
        model_reset();
        check_idle("rst_compare");
        @(negedge clk);
        check_idle("rst_compare2");

        // Random games.
        for (int g = 0; g < 5; g++) begin
            do_reset();
            check_idle("rnd_reset");
            for (int p = 0; p < 30; p++) begin
                do_press($urandom_range(0, N - 1), $urandom_range(1, 3));
                check_idle("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
